// File: rtl/sniffer_pkg.sv
// Shared sniffer datapath definitions: string geometry, loader FSM states
// and the byte type used by the loader and the string comparator.
package sniffer_pkg;

   localparam int MAX_STR_LEN = 17;
   localparam int STRLEN_W    = 5;

   typedef logic [7:0] byte_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      COMMIT = 2'd2,
      DRAIN  = 2'd3
   } loader_state_t;

endpackage

// File: rtl/match_string_loader.sv
// match_string_loader: byte-serial, double-buffered loader for the
// corrupt-match string. A shadow copy fills while the comparator keeps
// using the active copy; a one-cycle COMMIT swaps it in and pulses
// comp_clear. Overflowing strings are drained and flagged in load_err.
// Optional build macro LOADER_READBACK_EN adds a registered readback port
// (rd_idx / rd_data / rd_len) for verifying the programmed string.
module match_string_loader
   import sniffer_pkg::*;
#(
   parameter int MAX_LEN = MAX_STR_LEN
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  byte_t               cfg_data,
   input  logic                cfg_last,
   input  logic                cfg_abort,
   output byte_t               string_out [0:MAX_LEN-1],
   output logic [STRLEN_W-1:0] strlen_out,
   output logic                string_valid,
   output logic                comp_clear,
   output logic                load_err
`ifdef LOADER_READBACK_EN
   ,
   input  logic [STRLEN_W-1:0] rd_idx,
   output byte_t               rd_data,
   output logic [STRLEN_W-1:0] rd_len
`endif
);

   loader_state_t       state;
   loader_state_t       next_state;
   logic [STRLEN_W-1:0] cnt;
   byte_t               shadow [0:MAX_LEN-1];
   logic                xfer;
   logic                overflow;

   // Ready depends on state only, so the upstream handshake has no comb path.
   assign cfg_ready = (state != COMMIT);
   assign xfer      = cfg_valid && cfg_ready;
   // The shadow is full; any further byte in LOAD cannot be stored.
   assign overflow  = (cnt == STRLEN_W'(MAX_LEN));

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; abort takes priority over a coincident transfer.
   // A byte beyond the buffer is an overflow even when it carries cfg_last,
   // in which case the string is already finished and nothing needs draining.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (xfer) next_state = cfg_last ? COMMIT : LOAD;
         end
         LOAD: begin
            if (cfg_abort)     next_state = IDLE;
            else if (xfer) begin
               if (overflow)      next_state = cfg_last ? IDLE : DRAIN;
               else if (cfg_last) next_state = COMMIT;
            end
         end
         COMMIT: next_state = IDLE;
         DRAIN: begin
            if (cfg_abort)             next_state = IDLE;
            else if (xfer && cfg_last) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Shadow fill, atomic commit to the active copy, and status flags.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt          <= '0;
         strlen_out   <= '0;
         string_valid <= 1'b0;
         comp_clear   <= 1'b0;
         load_err     <= 1'b0;
         for (int i = 0; i < MAX_LEN; i++) begin
            shadow[i]     <= '0;
            string_out[i] <= '0;
         end
      end else begin
         comp_clear <= (state == COMMIT);
         case (state)
            IDLE: begin
               if (xfer) begin
                  shadow[0] <= cfg_data;
                  cnt       <= STRLEN_W'(1);
               end
            end
            LOAD: begin
               if (cfg_abort) begin
                  cnt <= '0;
               end else if (xfer) begin
                  if (overflow) begin
                     load_err <= 1'b1;
                     cnt      <= '0;
                  end else begin
                     shadow[cnt] <= cfg_data;
                     cnt         <= cnt + STRLEN_W'(1);
                  end
               end
            end
            COMMIT: begin
               // Entries beyond the new length may hold stale bytes from an
               // earlier, longer string; present them as zero.
               for (int i = 0; i < MAX_LEN; i++) begin
                  string_out[i] <= (STRLEN_W'(i) < cnt) ? shadow[i] : 8'h00;
               end
               strlen_out   <= cnt - STRLEN_W'(1);
               string_valid <= 1'b1;
               cnt          <= '0;
            end
            default: ;
         endcase
      end
   end

`ifdef LOADER_READBACK_EN
   // Registered readback of the active string; out-of-range indices read zero.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         rd_data <= '0;
         rd_len  <= '0;
      end else begin
         rd_data <= (rd_idx < STRLEN_W'(MAX_LEN)) ? string_out[rd_idx] : 8'h00;
         rd_len  <= strlen_out;
      end
   end
`endif

endmodule

// File: tb/tb_match_string_loader.sv
// Directed testbench for match_string_loader: a vector table for the basic
// load/commit timing plus hand-written sequences for overflow, abort,
// streaming, asynchronous reset and (when built with LOADER_READBACK_EN)
// the readback port.
module tb_match_string_loader;
   import sniffer_pkg::*;

   logic                clk = 1'b0;
   logic                n_rst;
   logic                cfg_valid;
   logic                cfg_ready;
   byte_t               cfg_data;
   logic                cfg_last;
   logic                cfg_abort;
   byte_t               string_out [0:MAX_STR_LEN-1];
   logic [STRLEN_W-1:0] strlen_out;
   logic                string_valid;
   logic                comp_clear;
   logic                load_err;
`ifdef LOADER_READBACK_EN
   logic [STRLEN_W-1:0] rd_idx;
   byte_t               rd_data;
   logic [STRLEN_W-1:0] rd_len;
`endif

   match_string_loader dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_data     (cfg_data),
      .cfg_last     (cfg_last),
      .cfg_abort    (cfg_abort),
      .string_out   (string_out),
      .strlen_out   (strlen_out),
      .string_valid (string_valid),
      .comp_clear   (comp_clear),
      .load_err     (load_err)
`ifdef LOADER_READBACK_EN
      ,
      .rd_idx       (rd_idx),
      .rd_data      (rd_data),
      .rd_len       (rd_len)
`endif
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int clr_cnt = 0;
   int rdy_low_cnt = 0;

   // Count comp_clear pulses and stalled cycles mid-cycle, away from edges.
   always @(negedge clk) begin
      if (comp_clear) clr_cnt++;
      if (n_rst && !cfg_ready) rdy_low_cnt++;
   end

   typedef struct {
      logic                v;
      byte_t               d;
      logic                l;
      logic                rdy;
      logic                clr;
      logic                sv;
      logic [STRLEN_W-1:0] len;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      cfg_abort = 1'b0;
      repeat (n) step();
   endtask

   // Present one byte and hold it until accepted (bounded wait on cfg_ready).
   task automatic send(input byte_t d, input logic last, input logic abort);
      int tries;
      cfg_valid = 1'b1;
      cfg_data  = d;
      cfg_last  = last;
      cfg_abort = abort;
      tries = 0;
      while (!cfg_ready && tries < 8) begin
         step();
         tries++;
      end
      if (!cfg_ready) chk("ready_timeout", 0, 1);
      step();
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      cfg_abort = 1'b0;
   endtask

   initial begin
      int base_clr;
      int base_rdy;

      vecs[0] = '{1'b1, 8'h45, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
      vecs[1] = '{1'b1, 8'h56, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
      vecs[2] = '{1'b1, 8'h49, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0};
      vecs[3] = '{1'b1, 8'h4C, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0};
      vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd3};
      vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 5'd3};

      n_rst     = 1'b0;
      cfg_valid = 1'b0;
      cfg_data  = 8'h00;
      cfg_last  = 1'b0;
      cfg_abort = 1'b0;
`ifdef LOADER_READBACK_EN
      rd_idx    = '0;
`endif
      #3;
      chk("rst_ready", int'(cfg_ready), 1);
      chk("rst_valid", int'(string_valid), 0);
      chk("rst_len", int'(strlen_out), 0);
      chk("rst_clear", int'(comp_clear), 0);
      chk("rst_err", int'(load_err), 0);
      chk("rst_str0", int'(string_out[0]), 0);
      @(negedge clk);
      n_rst = 1'b1;
      step();

      // "EVIL" through the vector table: one row per clock.
      for (int r = 0; r < 6; r++) begin
         cfg_valid = vecs[r].v;
         cfg_data  = vecs[r].d;
         cfg_last  = vecs[r].l;
         step();
         chk($sformatf("evil_rdy[%0d]", r), int'(cfg_ready), int'(vecs[r].rdy));
         chk($sformatf("evil_clr[%0d]", r), int'(comp_clear), int'(vecs[r].clr));
         chk($sformatf("evil_sv[%0d]", r), int'(string_valid), int'(vecs[r].sv));
         chk($sformatf("evil_len[%0d]", r), int'(strlen_out), int'(vecs[r].len));
         chk($sformatf("evil_err[%0d]", r), int'(load_err), 0);
      end
      cfg_valid = 1'b0;
      cfg_last  = 1'b0;
      chk("evil_s0", int'(string_out[0]), 'h45);
      chk("evil_s1", int'(string_out[1]), 'h56);
      chk("evil_s2", int'(string_out[2]), 'h49);
      chk("evil_s3", int'(string_out[3]), 'h4C);
      chk("evil_s4", int'(string_out[4]), 0);
      chk("evil_s16", int'(string_out[16]), 0);

`ifdef LOADER_READBACK_EN
      rd_idx = 5'd2;
      step();
      chk("rb_data2", int'(rd_data), 'h49);
      chk("rb_len", int'(rd_len), 3);
      rd_idx = 5'd20;
      step();
      chk("rb_data20", int'(rd_data), 0);
`endif

      // Full-length 17-byte string.
      base_clr = clr_cnt;
      for (int i = 0; i < 17; i++) send(byte_t'(8'h01 + i), (i == 16), 1'b0);
      idle(2);
      chk("full_len", int'(strlen_out), 16);
      chk("full_s0", int'(string_out[0]), 'h01);
      chk("full_s16", int'(string_out[16]), 'h11);
      chk("full_err", int'(load_err), 0);
      chk("full_clr", clr_cnt - base_clr, 1);

      // 18-byte string overflows; active string must survive.
      base_clr = clr_cnt;
      for (int i = 0; i < 18; i++) send(byte_t'(8'h20 + i), (i == 17), 1'b0);
      idle(3);
      chk("ovf_err", int'(load_err), 1);
      chk("ovf_len", int'(strlen_out), 16);
      chk("ovf_s0", int'(string_out[0]), 'h01);
      chk("ovf_s16", int'(string_out[16]), 'h11);
      chk("ovf_clr", clr_cnt - base_clr, 0);
      chk("ovf_ready", int'(cfg_ready), 1);

      // "AB", then "XYZ" aborted on 'Y', then "Q".
      send(8'h41, 1'b0, 1'b0);
      send(8'h42, 1'b1, 1'b0);
      idle(2);
      chk("ab_len", int'(strlen_out), 1);
      base_clr = clr_cnt;
      send(8'h58, 1'b0, 1'b0);
      send(8'h59, 1'b0, 1'b1);
      idle(2);
      chk("abort_clr", clr_cnt - base_clr, 0);
      chk("abort_len", int'(strlen_out), 1);
      chk("abort_s0", int'(string_out[0]), 'h41);
      chk("abort_s1", int'(string_out[1]), 'h42);
      send(8'h51, 1'b1, 1'b0);
      idle(2);
      chk("q_len", int'(strlen_out), 0);
      chk("q_s0", int'(string_out[0]), 'h51);
      chk("q_s1", int'(string_out[1]), 0);
      chk("q_clr", clr_cnt - base_clr, 1);

      // Back-to-back "AA" / "BBB" with cfg_valid held.
      base_clr = clr_cnt;
      base_rdy = rdy_low_cnt;
      send(8'h41, 1'b0, 1'b0);
      send(8'h41, 1'b1, 1'b0);
      send(8'h42, 1'b0, 1'b0);
      send(8'h42, 1'b0, 1'b0);
      send(8'h42, 1'b1, 1'b0);
      idle(3);
      chk("stream_rdylow", rdy_low_cnt - base_rdy, 2);
      chk("stream_clr", clr_cnt - base_clr, 2);
      chk("stream_len", int'(strlen_out), 2);
      chk("stream_s2", int'(string_out[2]), 'h42);
      chk("stream_s3", int'(string_out[3]), 0);

      // Asynchronous reset during the third byte of a 5-byte load.
      send(8'h61, 1'b0, 1'b0);
      send(8'h62, 1'b0, 1'b0);
      cfg_valid = 1'b1;
      cfg_data  = 8'h63;
      #2;
      n_rst = 1'b0;
      #1;
      chk("arst_valid", int'(string_valid), 0);
      chk("arst_len", int'(strlen_out), 0);
      chk("arst_err", int'(load_err), 0);
      chk("arst_s0", int'(string_out[0]), 0);
      chk("arst_clr", int'(comp_clear), 0);
      chk("arst_ready", int'(cfg_ready), 1);
      cfg_valid = 1'b0;
      #3;
      n_rst = 1'b1;
      step();
      send(8'h43, 1'b1, 1'b0);
      idle(2);
      chk("c_valid", int'(string_valid), 1);
      chk("c_len", int'(strlen_out), 0);
      chk("c_s0", int'(string_out[0]), 'h43);
      chk("c_s1", int'(string_out[1]), 0);
      chk("c_err", int'(load_err), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
